// File: rtl/fib_job_scheduler_pkg.sv
// Shared types and constants for the Fibonacci job scheduler: FSM encoding,
// response codes and default widths.
package fib_job_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] RSP_OK    = 2'b00;
    localparam logic [1:0] RSP_RANGE = 2'b01;
    localparam logic [1:0] RSP_TMO   = 2'b10;

    localparam int N_W_DEF     = 5;
    localparam int CNT_W_DEF   = 16;
    localparam int QDEPTH_DEF  = 4;
    localparam int N_MAX_DEF   = 24;
    localparam int TIMEOUT_DEF = 4096;

    // Width of the run watchdog, able to hold the value TIMEOUT itself
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fib_job_scheduler_if.sv
// Request, response and engine-control signals of the scheduler in one bundle.
// The slave modport is the scheduler's view; master is the client/engine side.
interface fib_job_scheduler_if #(
    parameter int N_W   = 5,
    parameter int CNT_W = 16
) ();
    logic             req_valid;
    logic             req_ready;
    logic [N_W-1:0]   req_n;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [CNT_W-1:0] rsp_result;
    logic [1:0]       rsp_err;
    logic             eng_start;
    logic [N_W-1:0]   eng_n;
    logic             eng_abort;
    logic             eng_done;
    logic [CNT_W-1:0] eng_count;
    logic             busy;

    modport slave (
        input  req_valid, req_n, rsp_ready, eng_done, eng_count,
        output req_ready, rsp_valid, rsp_result, rsp_err,
               eng_start, eng_n, eng_abort, busy
    );

    modport master (
        output req_valid, req_n, rsp_ready, eng_done, eng_count,
        input  req_ready, rsp_valid, rsp_result, rsp_err,
               eng_start, eng_n, eng_abort, busy
    );
endinterface

// File: rtl/fib_job_scheduler_req_fifo.sv
// Small synchronous FIFO holding pending request operands; head is visible
// combinationally so the scheduler can pop and decode it in the same cycle.
module fib_req_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_wr;
    logic do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign rd_data = mem[rd_ptr_reg];

    // Storage carries no reset; only pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_wr && !do_rd) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (do_rd && !do_wr) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fib_job_scheduler.sv
// Front-end sequencer for the stack-based Fibonacci engine: queues requests,
// launches one job at a time, range-checks and watchdogs it, returns a response.
module fib_job_scheduler
    import fib_job_scheduler_pkg::*;
#(
    parameter int N_W     = N_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int QDEPTH  = QDEPTH_DEF,
    parameter int N_MAX   = N_MAX_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic                clk,
    input logic                CLR,
    fib_job_scheduler_if.slave bus
);
    localparam int TMR_W = timer_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [N_W-1:0]   N_LIMIT  = N_W'(N_MAX);

    state_t           state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [N_W-1:0]   eng_n_reg;
    logic             eng_start_reg;
    logic             eng_abort_reg;
    logic             rsp_valid_reg;
    logic [CNT_W-1:0] rsp_result_reg;
    logic [1:0]       rsp_err_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [N_W-1:0]   fifo_head;

    assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;

    fib_req_fifo #(
        .WIDTH (N_W),
        .DEPTH (QDEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .CLR     (CLR),
        .wr_en   (bus.req_valid),
        .wr_data (bus.req_n),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.req_ready  = !fifo_full;
    assign bus.busy       = (state_reg != ST_IDLE) || !fifo_empty;
    assign bus.eng_start  = eng_start_reg;
    assign bus.eng_abort  = eng_abort_reg;
    assign bus.eng_n      = eng_n_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_err    = rsp_err_reg;

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= '0;
            eng_n_reg      <= '0;
            eng_start_reg  <= 1'b0;
            eng_abort_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_err_reg    <= RSP_OK;
        end else begin
            eng_start_reg <= 1'b0;
            eng_abort_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        eng_n_reg <= fifo_head;
                        if (fifo_head > N_LIMIT) begin
                            rsp_result_reg <= '0;
                            rsp_err_reg    <= RSP_RANGE;
                            rsp_valid_reg  <= 1'b1;
                            state_reg      <= ST_HOLD;
                        end else begin
                            eng_start_reg <= 1'b1;
                            state_reg     <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    timer_reg <= '0;
                    state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    timer_reg <= timer_reg + TMR_W'(1);
                    // A completion in the last watchdog cycle still counts as success
                    if (bus.eng_done) begin
                        rsp_result_reg <= bus.eng_count;
                        rsp_err_reg    <= RSP_OK;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= ST_HOLD;
                    end else if (timer_reg == TMR_LAST) begin
                        eng_abort_reg  <= 1'b1;
                        rsp_result_reg <= '0;
                        rsp_err_reg    <= RSP_TMO;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Directed bench for fib_job_scheduler with a behavioural engine that answers
// fib(n) a fixed number of RUN cycles after each launch.
module tb_fib_job_scheduler;
    import fib_job_scheduler_pkg::*;

    localparam int N_W     = 5;
    localparam int CNT_W   = 16;
    localparam int QDEPTH  = 4;
    localparam int N_MAX   = 24;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic CLR;
    always #5 clk = ~clk;

    fib_job_scheduler_if #(.N_W(N_W), .CNT_W(CNT_W)) dif ();

    fib_job_scheduler #(
        .N_W     (N_W),
        .CNT_W   (CNT_W),
        .QDEPTH  (QDEPTH),
        .N_MAX   (N_MAX),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .CLR (CLR),
        .bus (dif)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int start_cnt = 0;
    int abort_cnt = 0;
    int model_delay = 3;
    bit model_never = 1'b0;
    int inject_req = 0;

    typedef struct {
        logic [N_W-1:0]   n;
        logic [CNT_W-1:0] res;
        logic [1:0]       err;
    } vec_t;
    vec_t vecs [9];

    function automatic logic [CNT_W-1:0] fib(input logic [N_W-1:0] n);
        logic [CNT_W-1:0] a, b, t;
        a = '0;
        b = CNT_W'(1);
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine model: done pulse in RUN cycle model_delay after the launch cycle
    initial begin
        int cnt;
        int inject_ack;
        logic [N_W-1:0] n;
        bit pend;
        pend = 1'b0;
        cnt = 0;
        inject_ack = 0;
        n = '0;
        dif.eng_done = 1'b0;
        dif.eng_count = '0;
        forever begin
            @(negedge clk);
            dif.eng_done = 1'b0;
            if (dif.eng_start) start_cnt++;
            if (dif.eng_abort) abort_cnt++;
            if (CLR) begin
                pend = 1'b0;
            end else if (inject_req != inject_ack) begin
                inject_ack = inject_req;
                dif.eng_done = 1'b1;
                dif.eng_count = 16'h1234;
            end else if (dif.eng_start) begin
                pend = 1'b1;
                cnt = 0;
                n = dif.eng_n;
            end else if (pend) begin
                if (dif.eng_abort) begin
                    pend = 1'b0;
                end else begin
                    cnt++;
                    if (!model_never && cnt == model_delay) begin
                        dif.eng_done = 1'b1;
                        dif.eng_count = fib(n);
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one request; returns at the negedge after it was accepted
    task automatic send(input logic [N_W-1:0] n);
        int w;
        dif.req_valid = 1'b1;
        dif.req_n = n;
        w = 0;
        while (!dif.req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("send_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        dif.req_valid = 1'b0;
    endtask

    task automatic recv(input logic [CNT_W-1:0] res, input logic [1:0] err, input string name);
        int w;
        w = 0;
        while (!dif.rsp_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_valid"}, 32'(dif.rsp_valid), 32'd1);
        chk({name, "_result"}, 32'(dif.rsp_result), 32'(res));
        chk({name, "_err"}, 32'(dif.rsp_err), 32'(err));
        $display("rsp %s: result=%0d err=%0b", name, dif.rsp_result, dif.rsp_err);
        dif.rsp_ready = 1'b1;
        @(negedge clk);
        dif.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, s0, a0, w;
        bit seen;

        vecs[0] = '{5'd10, 16'd55,    RSP_OK};
        vecs[1] = '{5'd0,  16'd0,     RSP_OK};
        vecs[2] = '{5'd1,  16'd1,     RSP_OK};
        vecs[3] = '{5'd2,  16'd1,     RSP_OK};
        vecs[4] = '{5'd12, 16'd144,   RSP_OK};
        vecs[5] = '{5'd20, 16'd6765,  RSP_OK};
        vecs[6] = '{5'd24, 16'd46368, RSP_OK};
        vecs[7] = '{5'd25, 16'd0,     RSP_RANGE};
        vecs[8] = '{5'd31, 16'd0,     RSP_RANGE};

        dif.req_valid = 1'b0;
        dif.req_n = '0;
        dif.rsp_ready = 1'b0;
        CLR = 1'b1;
        tick(2);
        chk("rst_req_ready", 32'(dif.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(dif.rsp_valid), 32'd0);
        chk("rst_eng_start", 32'(dif.eng_start), 32'd0);
        chk("rst_eng_abort", 32'(dif.eng_abort), 32'd0);
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_rsp_result", 32'(dif.rsp_result), 32'd0);
        chk("rst_rsp_err", 32'(dif.rsp_err), 32'd0);
        chk("rst_eng_n", 32'(dif.eng_n), 32'd0);
        CLR = 1'b0;
        tick(1);

        // Single job latency: start two cycles after accept, response four after start
        send(5'd10);
        chk("t1_start_early", 32'(dif.eng_start), 32'd0);
        tick(1);
        chk("t1_start", 32'(dif.eng_start), 32'd1);
        chk("t1_eng_n", 32'(dif.eng_n), 32'd10);
        lat = 0;
        while (!dif.rsp_valid && lat < 50) begin
            tick(1);
            lat++;
        end
        chk("t1_rsp_latency", 32'(lat), 32'd4);
        recv(16'd55, RSP_OK, "t1");

        // Table of single jobs, including both range-error operands
        for (int i = 0; i < 9; i++) begin
            s0 = start_cnt;
            send(vecs[i].n);
            recv(vecs[i].res, vecs[i].err, $sformatf("vec%0d_n%0d", i, vecs[i].n));
            chk($sformatf("vec%0d_launches", i), 32'(start_cnt - s0),
                (vecs[i].err == RSP_OK) ? 32'd1 : 32'd0);
        end

        // Backpressure: five requests while the consumer stalls
        send(5'd3);
        send(5'd5);
        send(5'd7);
        send(5'd9);
        send(5'd11);
        chk("bp_req_ready_full", 32'(dif.req_ready), 32'd0);
        chk("bp_busy", 32'(dif.busy), 32'd1);
        w = 0;
        while (!dif.rsp_valid && w < 100) begin
            tick(1);
            w++;
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk($sformatf("bp_hold_valid%0d", i), 32'(dif.rsp_valid), 32'd1);
            chk($sformatf("bp_hold_result%0d", i), 32'(dif.rsp_result), 32'd2);
        end
        recv(16'd2,  RSP_OK, "bp0");
        recv(16'd5,  RSP_OK, "bp1");
        recv(16'd13, RSP_OK, "bp2");
        recv(16'd34, RSP_OK, "bp3");
        recv(16'd89, RSP_OK, "bp4");

        // Timeout: engine never finishes; abort after 16 RUN cycles
        model_never = 1'b1;
        a0 = abort_cnt;
        send(5'd6);
        send(5'd7);
        chk("tmo_start", 32'(dif.eng_start), 32'd1);
        lat = 0;
        while (!dif.eng_abort && lat < 100) begin
            tick(1);
            lat++;
        end
        chk("tmo_abort_latency", 32'(lat), 32'd17);
        chk("tmo_rsp_valid_with_abort", 32'(dif.rsp_valid), 32'd1);
        model_never = 1'b0;
        tick(1);
        chk("tmo_abort_one_cycle", 32'(dif.eng_abort), 32'd0);
        recv(16'd0, RSP_TMO, "tmo");
        recv(16'd13, RSP_OK, "tmo_next");
        chk("tmo_abort_count", 32'(abort_cnt - a0), 32'd1);

        // Race: done in the final watchdog cycle beats the timeout
        model_delay = 16;
        a0 = abort_cnt;
        send(5'd8);
        recv(16'd21, RSP_OK, "race");
        chk("race_no_abort", 32'(abort_cnt - a0), 32'd0);
        model_delay = 3;

        // Stray done while idle must be ignored
        tick(1);
        chk("idle_busy", 32'(dif.busy), 32'd0);
        s0 = start_cnt;
        seen = 1'b0;
        inject_req++;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (dif.rsp_valid || dif.busy) seen = 1'b1;
        end
        chk("idle_done_ignored", 32'(seen), 32'd0);
        chk("idle_no_start", 32'(start_cnt - s0), 32'd0);

        // Reset in RUN with three jobs queued
        model_never = 1'b1;
        s0 = start_cnt;
        a0 = abort_cnt;
        send(5'd1);
        send(5'd2);
        send(5'd3);
        send(5'd4);
        tick(1);
        chk("rst_run_busy_before", 32'(dif.busy), 32'd1);
        CLR = 1'b1;
        #1;
        chk("rst_run_busy", 32'(dif.busy), 32'd0);
        chk("rst_run_req_ready", 32'(dif.req_ready), 32'd1);
        chk("rst_run_rsp_valid", 32'(dif.rsp_valid), 32'd0);
        chk("rst_run_eng_start", 32'(dif.eng_start), 32'd0);
        chk("rst_run_eng_abort", 32'(dif.eng_abort), 32'd0);
        chk("rst_run_eng_n", 32'(dif.eng_n), 32'd0);
        @(negedge clk);
        CLR = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (dif.rsp_valid || dif.busy) seen = 1'b1;
        end
        chk("rst_run_no_rsp_after", 32'(seen), 32'd0);
        chk("rst_run_launches", 32'(start_cnt - s0), 32'd1);
        chk("rst_run_no_abort", 32'(abort_cnt - a0), 32'd0);
        model_never = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
